// File: rtl/halt_ctrl_pkg.sv
// Shared core definitions for the halt controller: FSM states and the ebreak encoding.
package halt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALTED = 2'd3
    } halt_state_e;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    function automatic logic is_ebreak(input logic valid, input logic [31:0] inst);
        return valid && (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/halt_ctrl.sv
// Halt controller: on a retiring ebreak, freezes the core, drains the pipeline
// (bounded by DRAIN_TIMEOUT), reports the exit code to the harness, then halts.
module halt_ctrl
    import halt_ctrl_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wb_valid,
    input  logic [31:0]     wb_inst,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [XLEN-1:0] a0_value,
    input  logic            pipe_empty,
    input  logic            halt_ready,
    output logic            stall_req,
    output logic            halt_valid,
    output logic [31:0]     halt_code,
    output logic [XLEN-1:0] halt_pc,
    output logic            halt_timeout,
    output logic            halted,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
);

    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    halt_state_e     state_q;
    logic [CNT_W-1:0] drain_cnt_q;
    logic            stall_q;
    logic            valid_q;
    logic            halted_q;
    logic            timeout_q;
    logic [31:0]     code_q;
    logic [XLEN-1:0] pc_q;
    logic [63:0]     cycle_cnt_q;
    logic [63:0]     instret_cnt_q;

    logic ebreak;
    assign ebreak = is_ebreak(wb_valid, wb_inst);

    // Only the low word of a0 is the exit code; the rest is deliberately dropped.
    logic unused_a0_hi;
    assign unused_a0_hi = ^a0_value;

    // NOTE: every register below uses non-blocking assignments so all state
    // updates on an edge see the pre-edge values, whatever order they are written in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= '0;
            stall_q       <= 1'b0;
            valid_q       <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            code_q        <= '0;
            pc_q          <= '0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cycle_cnt_q <= cycle_cnt_q + 64'd1;
                    if (wb_valid) begin
                        instret_cnt_q <= instret_cnt_q + 64'd1;
                    end
                    if (ebreak) begin
                        code_q      <= a0_value[31:0];
                        pc_q        <= wb_pc;
                        drain_cnt_q <= '0;
                        stall_q     <= 1'b1;
                        state_q     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    cycle_cnt_q <= cycle_cnt_q + 64'd1;
                    // pipe_empty wins over the timeout when both happen on the last cycle.
                    if (pipe_empty) begin
                        timeout_q <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= ST_REPORT;
                    end else if (drain_cnt_q == DRAIN_LAST) begin
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_REPORT;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (halt_ready) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_req    = stall_q;
    assign halt_valid   = valid_q;
    assign halt_code    = code_q;
    assign halt_pc      = pc_q;
    assign halt_timeout = timeout_q;
    assign halted       = halted_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign instret_cnt  = instret_cnt_q;

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning architectural register and PC width.
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 16, meaning maximum cycles spent in DRAIN.
REQ-003 SHALL have port clock  input  1  core clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wb_valid  input  1  an instruction retires this cycle.
REQ-006 SHALL have port wb_inst  input  32  retiring instruction word.
REQ-007 SHALL have port wb_pc  input  XLEN  PC of retiring instruction.
REQ-008 SHALL have port a0_value  input  XLEN  architectural x10, bypassed to include the retiring write.
REQ-009 SHALL have port pipe_empty  input  1  no instruction or store in flight.
REQ-010 SHALL have port halt_ready  input  1  simulation harness accepts the halt report.
REQ-011 SHALL have port stall_req  output  1  freezes fetch and commit.
REQ-012 SHALL have port halt_valid  output  1  halt report valid.
REQ-013 SHALL have port halt_code  output  32  exit code, a0_value[31:0] captured at ebreak.
REQ-014 SHALL have port halt_pc  output  XLEN  PC of the ebreak.
REQ-015 SHALL have port halt_timeout  output  1  drain ended by timeout, not by pipe_empty.
REQ-016 SHALL have port halted  output  1  terminal state reached.
REQ-017 SHALL have ports cycle_cnt and instret_cnt  output  64 each  cycle and retired-instruction counters.

Function
REQ-018 SHALL detect ebreak as wb_valid==1 and wb_inst==32'h00100073; all other encodings count as normal retires.
REQ-019 SHALL implement states IDLE, DRAIN, REPORT and HALTED, held in a registered state variable.
REQ-020 In IDLE, on ebreak detect, SHALL capture halt_code and halt_pc, clear the drain counter and enter DRAIN the next cycle.
REQ-021 SHALL drive stall_req=1 in DRAIN, REPORT and HALTED, and 0 in IDLE.
REQ-022 SHALL spend at least one cycle in DRAIN even when pipe_empty is already high in the ebreak cycle.
REQ-023 In DRAIN, SHALL enter REPORT when pipe_empty==1, with halt_timeout=0.
REQ-024 In DRAIN, when the counter reaches DRAIN_TIMEOUT-1 with pipe_empty==0, SHALL enter REPORT with halt_timeout=1.
REQ-025 In REPORT, SHALL hold halt_valid=1 and keep halt_code, halt_pc and halt_timeout stable until halt_ready==1.
REQ-026 On halt_valid and halt_ready both high, SHALL enter HALTED the next cycle and drop halt_valid.
REQ-027 SHALL ignore halt_ready in every state other than REPORT.
REQ-028 HALTED SHALL be terminal until reset and SHALL drive halted=1.
REQ-029 SHALL increment cycle_cnt every cycle in IDLE and DRAIN and freeze it from REPORT onward.
REQ-030 SHALL increment instret_cnt on each wb_valid in IDLE, with the ebreak counted, and ignore wb_valid in all other states.
REQ-031 Both counters SHALL wrap modulo 2^64 without flagging.
REQ-032 Latency: an ebreak retiring at cycle N with pipe_empty high gives stall_req=1 at N+1 and halt_valid=1 at N+2.

Reset
REQ-033 Assertion of reset_n=0 SHALL immediately force state=IDLE and clear the captured values and all outputs, with stall_req, halt_valid, halted and halt_timeout=0 and halt_code, halt_pc, cycle_cnt and instret_cnt=0.
REQ-034 Reset asserted in DRAIN, REPORT or HALTED SHALL abort the halt sequence without emitting a report.
REQ-035 Deassertion SHALL take effect at the first rising clock edge after release.

Structure
REQ-036 SHALL place the state enumeration and the EBREAK_INST constant (32'h00100073) in the shared core package.
REQ-037 SHALL be a single module with no sub-modules; the counters stay inline.

Verification
REQ-038 Verify: ebreak with a0=0x0000_0000_0000_002A and pipe_empty=1 -> halt_valid at N+2, halt_code=0x2A, halt_timeout=0.
REQ-039 Verify: pipe_empty held 0 after ebreak -> REPORT after exactly 16 DRAIN cycles, halt_timeout=1.
REQ-040 Verify: halt_ready held low 5 cycles in REPORT -> halt_valid and halt_code stable throughout; halted=1 one cycle after the handshake.
REQ-041 Verify: 10 normal retires then ebreak, followed by wb_valid pulses during DRAIN -> instret_cnt=11, frozen.
REQ-042 Verify: reset_n pulsed low mid-REPORT -> all outputs 0 asynchronously and a later ebreak is reported normally.
REQ-043 Verify: halt_ready high in IDLE and a non-ebreak word 0x00000073 retiring -> no state change and stall_req=0.
